// File: rtl/cle_pkg.sv
// Shared types and constants for the CLE serial key reader.
package cle_pkg;

  // Byte packing and field widths
  localparam int BYTE_W    = 8;
  localparam int BIT_IDX_W = $clog2(BYTE_W);
  localparam int LEN_W     = 8;
  localparam int SEL_W     = 4;
  localparam int TMR_W     = 8;

  // Address decode levels that select the key GAL
  localparam logic SEL_BA13 = 1'b0;
  localparam logic SEL_BA12 = 1'b1;

  // One gated read cycle per bit, plus a byte hand-off phase
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_SAMPLE,
    ST_EMIT
  } state_e;

  // A phase lasting N cycles loads the down-counter with N-1 so that the
  // counter reaches zero on the phase's last cycle.
  function automatic logic [TMR_W-1:0] phase_load(input int cycles);
    return TMR_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/cle_bit_timer.sv
// Loadable down-counter that measures the length of each bit phase.
module cle_bit_timer
  import cle_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  // Load on phase entry, then count down and park at zero
  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_load_val;
    else if (r_cnt != '0)
      r_cnt <= r_cnt - 1'b1;
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/cle_key_reader.sv
// Host-side initiator for the CLE serial key: clocks the key once per bit,
// samples SDRD and hands the bits to the CPU side packed LSB-first in bytes.
module cle_key_reader
  import cle_pkg::*;
#(
  parameter int T_SETUP  = 2,
  parameter int T_HIGH   = 2,
  parameter int T_SAMPLE = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [SEL_W-1:0]  i_cmd_sel,
  input  logic [LEN_W-1:0]  i_cmd_len,
  output logic [BYTE_W-1:0] o_data,
  output logic              o_data_valid,
  input  logic              i_data_ready,
  output logic              o_data_last,
  output logic              o_busy,
  output logic              o_SSER,
  output logic              o_BA13,
  output logic              o_BA12,
  output logic [SEL_W-1:0]  o_BA_SEL,
  output logic              o_BR_W,
  output logic              o_key_clk,
  input  logic              i_SDRD
);

  state_e             r_state;
  state_e             w_next;

  logic [SEL_W-1:0]   r_sel;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_bitcnt;
  logic [BYTE_W-1:0]  r_shift;

  logic [LEN_W-1:0]   w_bitcnt_nxt;
  logic               w_last;
  logic               w_selected;
  logic               w_accept;
  logic               w_sample;
  logic               w_take;
  logic               w_tmr_load;
  logic [TMR_W-1:0]   w_tmr_val;
  logic               w_tmr_done;

  cle_bit_timer #(.W(TMR_W)) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_done     (w_tmr_done)
  );

  assign w_bitcnt_nxt = r_bitcnt + 1'b1;
  assign w_last       = (r_bitcnt == r_len);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  // Next-state, phase timer loads and datapath strobes
  always_comb begin
    w_next     = r_state;
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    w_accept   = 1'b0;
    w_sample   = 1'b0;
    w_take     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          w_accept = 1'b1;
          // A zero-length command is consumed without touching the key
          if (i_cmd_len != '0) begin
            w_next     = ST_SETUP;
            w_tmr_load = 1'b1;
            w_tmr_val  = phase_load(T_SETUP);
          end
        end
      end
      ST_SETUP: begin
        if (w_tmr_done) begin
          w_next     = ST_HIGH;
          w_tmr_load = 1'b1;
          w_tmr_val  = phase_load(T_HIGH);
        end
      end
      ST_HIGH: begin
        if (w_tmr_done) begin
          w_next     = ST_SAMPLE;
          w_tmr_load = 1'b1;
          w_tmr_val  = phase_load(T_SAMPLE);
        end
      end
      ST_SAMPLE: begin
        if (w_tmr_done) begin
          w_sample = 1'b1;
          // Hand off on a full byte or on the final bit of the command
          if ((w_bitcnt_nxt[BIT_IDX_W-1:0] == '0) || (w_bitcnt_nxt == r_len)) begin
            w_next = ST_EMIT;
          end else begin
            w_next     = ST_SETUP;
            w_tmr_load = 1'b1;
            w_tmr_val  = phase_load(T_SETUP);
          end
        end
      end
      ST_EMIT: begin
        if (i_data_ready) begin
          w_take = 1'b1;
          if (w_last) begin
            w_next = ST_IDLE;
          end else begin
            w_next     = ST_SETUP;
            w_tmr_load = 1'b1;
            w_tmr_val  = phase_load(T_SETUP);
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Command latch, bit counter and byte assembly
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sel    <= '0;
      r_len    <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
    end else begin
      if (w_accept) begin
        r_sel    <= i_cmd_sel;
        r_len    <= i_cmd_len;
        r_bitcnt <= '0;
        r_shift  <= '0;
      end
      if (w_sample) begin
        r_shift[r_bitcnt[BIT_IDX_W-1:0]] <= i_SDRD;
        r_bitcnt                         <= w_bitcnt_nxt;
      end
      if (w_take)
        r_shift <= '0;
    end
  end

  // The key stays selected from accept to final hand-off so it sees one
  // continuous read cycle; all bus lines decode straight from the state.
  assign w_selected   = (r_state != ST_IDLE);

  assign o_cmd_ready  = (r_state == ST_IDLE);
  assign o_busy       = w_selected;
  assign o_SSER       = ~w_selected;
  assign o_BA13       = w_selected ? SEL_BA13 : 1'b1;
  assign o_BA12       = w_selected ? SEL_BA12 : 1'b0;
  assign o_BA_SEL     = w_selected ? r_sel : '0;
  assign o_BR_W       = w_selected;
  assign o_key_clk    = (r_state == ST_HIGH);

  assign o_data_valid = (r_state == ST_EMIT);
  assign o_data       = o_data_valid ? r_shift : '0;
  assign o_data_last  = o_data_valid & w_last;

endmodule

// File: tb/tb_cle_key_reader.sv
// Directed + randomized bench for cle_key_reader with a behavioural key model.
module tb_cle_key_reader;

  localparam int T_SETUP  = 2;
  localparam int T_HIGH   = 2;
  localparam int T_SAMPLE = 1;
  localparam int LAT_BIT  = T_SETUP + T_HIGH + T_SAMPLE;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_cmd_valid = 1'b0;
  logic       o_cmd_ready;
  logic [3:0] i_cmd_sel = '0;
  logic [7:0] i_cmd_len = '0;
  logic [7:0] o_data;
  logic       o_data_valid;
  logic       i_data_ready = 1'b1;
  logic       o_data_last;
  logic       o_busy;
  logic       o_SSER;
  logic       o_BA13;
  logic       o_BA12;
  logic [3:0] o_BA_SEL;
  logic       o_BR_W;
  logic       o_key_clk;
  logic       key_q = 1'b0;

  always #5 clk = ~clk;

  cle_key_reader #(.T_SETUP(T_SETUP), .T_HIGH(T_HIGH), .T_SAMPLE(T_SAMPLE)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_sel(i_cmd_sel), .i_cmd_len(i_cmd_len),
    .o_data(o_data), .o_data_valid(o_data_valid), .i_data_ready(i_data_ready),
    .o_data_last(o_data_last), .o_busy(o_busy),
    .o_SSER(o_SSER), .o_BA13(o_BA13), .o_BA12(o_BA12), .o_BA_SEL(o_BA_SEL),
    .o_BR_W(o_BR_W), .o_key_clk(o_key_clk), .i_SDRD(key_q)
  );

  int ncmp = 0;
  int nfail = 0;

  // Key model state and observation records
  logic       key_bits[$];
  int         key_idx = 0;
  int         pulses = 0;
  int         bus_err = 0;
  int         stable_err = 0;
  logic [3:0] exp_sel = '0;
  logic       kclk_prev = 1'b0;
  logic       dv_prev = 1'b0, rdy_prev = 1'b0, last_prev = 1'b0;
  logic [7:0] d_prev = '0;
  logic [7:0] got_d[$];
  logic       got_l[$];
  logic [7:0] exp_d[$];
  logic       exp_l[$];
  int         ready_mode = 1;   // 0 = held low, 1 = held high, 2 = random

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Consumer-side ready driver
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       i_data_ready = 1'b0;
      1:       i_data_ready = 1'b1;
      default: i_data_ready = ($urandom_range(0, 1) == 1);
    endcase
  end

  // Key GAL model + bus/handshake monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (o_key_clk && !kclk_prev) begin
        pulses++;
        key_q = (key_idx < key_bits.size()) ? key_bits[key_idx] : 1'b0;
        key_idx++;
        if (o_SSER !== 1'b0) bus_err++;
      end
      if (o_busy === 1'b1) begin
        if (o_SSER !== 1'b0 || o_BA13 !== 1'b0 || o_BA12 !== 1'b1 ||
            o_BR_W !== 1'b1 || o_BA_SEL !== exp_sel) bus_err++;
      end
      if (o_data_valid && dv_prev && !rdy_prev &&
          (o_data !== d_prev || o_data_last !== last_prev)) stable_err++;
      if (o_data_valid && i_data_ready) begin
        got_d.push_back(o_data);
        got_l.push_back(o_data_last);
      end
    end
    kclk_prev = o_key_clk;
    dv_prev   = o_data_valid;
    rdy_prev  = i_data_ready;
    d_prev    = o_data;
    last_prev = o_data_last;
  end

  // mode 0 = random, 1 = all ones
  task automatic load_key(input int n, input int mode);
    key_bits.delete();
    for (int i = 0; i < n; i++)
      key_bits.push_back(mode == 1 ? 1'b1 : ($urandom_range(0, 1) == 1));
    key_idx = 0;
    pulses  = 0;
    got_d.delete();
    got_l.delete();
  endtask

  // Reference: bits packed LSB-first into bytes, last byte flagged
  task automatic expect_bytes(input int len);
    exp_d.delete();
    exp_l.delete();
    for (int b = 0; b * 8 < len; b++) begin
      logic [7:0] v;
      v = '0;
      for (int i = 0; i < 8 && b * 8 + i < len; i++) v[i] = key_bits[b * 8 + i];
      exp_d.push_back(v);
      exp_l.push_back((b + 1) * 8 >= len);
    end
  endtask

  task automatic check_bytes(input string tag);
    chk({tag, "_nbytes"}, 32'(got_d.size()), 32'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), 32'(got_d[i]), 32'(exp_d[i]));
      chk($sformatf("%s_last%0d", tag, i), 32'(got_l[i]), 32'(exp_l[i]));
    end
  endtask

  task automatic start_cmd(input logic [3:0] sel, input logic [7:0] len);
    chk("cmd_ready_idle", 32'(o_cmd_ready), 32'd1);
    exp_sel     = sel;
    i_cmd_sel   = sel;
    i_cmd_len   = len;
    i_cmd_valid = 1'b1;
    tick();
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget, output int cyc);
    cyc = 0;
    while (o_busy && cyc < budget) begin
      tick();
      cyc++;
    end
    chk({tag, "_done"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int p0;
    logic [7:0] d0;
    logic l0;
    logic rose;
    int len;

    rst = 1'b1;
    repeat (3) tick();
    chk("rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
    chk("rst_outs", 32'({o_data, o_data_valid, o_data_last, o_busy}), 32'd0);
    chk("rst_bus", 32'({o_SSER, o_BA13, o_BA12, o_BA_SEL, o_BR_W, o_key_clk}), 32'b1_1_0_0000_0_0);
    rst = 1'b0;
    tick();

    // 1: single byte, fixed pattern
    ready_mode = 1;
    load_key(0, 0);
    key_bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    start_cmd(4'h2, 8'd8);
    wait_idle("t1", 200, cyc);
    chk("t1_cycles", 32'(cyc), 32'(8 * LAT_BIT + 1));
    chk("t1_pulses", 32'(pulses), 32'd8);
    chk("t1_bus", 32'(bus_err), 32'd0);
    chk("t1_nbytes", 32'(got_d.size()), 32'd1);
    if (got_d.size() > 0) begin
      chk("t1_data", 32'(got_d[0]), 32'h4D);
      chk("t1_last", 32'(got_l[0]), 32'd1);
    end

    // 2: zero-length command
    load_key(8, 0);
    start_cmd(4'h3, 8'd0);
    rose = 1'b0;
    repeat (10) begin
      if (o_busy || !o_cmd_ready) rose = 1'b1;
      tick();
    end
    chk("t2_busy_rose", 32'(rose), 32'd0);
    chk("t2_pulses", 32'(pulses), 32'd0);
    chk("t2_nbytes", 32'(got_d.size()), 32'd0);

    // 3: partial trailing byte
    load_key(11, 1);
    start_cmd(4'h7, 8'd11);
    wait_idle("t3", 300, cyc);
    chk("t3_cycles", 32'(cyc), 32'(11 * LAT_BIT + 2));
    chk("t3_nbytes", 32'(got_d.size()), 32'd2);
    if (got_d.size() == 2) begin
      chk("t3_d0", 32'({got_l[0], got_d[0]}), 32'h0FF);
      chk("t3_d1", 32'({got_l[1], got_d[1]}), 32'h107);
    end

    // 4: consumer stall during EMIT
    ready_mode = 0;
    tick();
    load_key(8, 0);
    start_cmd(4'h9, 8'd8);
    cyc = 0;
    while (!o_data_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("t4_valid_seen", 32'(o_data_valid), 32'd1);
    p0 = pulses;
    d0 = o_data;
    l0 = o_data_last;
    repeat (20) tick();
    chk("t4_no_pulses", 32'(pulses), 32'(p0));
    chk("t4_valid_held", 32'(o_data_valid), 32'd1);
    chk("t4_data_held", 32'({l0, d0}), 32'({o_data_last, o_data}));
    chk("t4_stable", 32'(stable_err), 32'd0);
    ready_mode = 1;
    wait_idle("t4", 100, cyc);
    expect_bytes(8);
    check_bytes("t4");

    // 5: reset mid-command, then a fresh command
    load_key(16, 0);
    start_cmd(4'h5, 8'd16);
    cyc = 0;
    while (!(pulses == 3 && !o_key_clk) && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("t5_pulse3", 32'(pulses), 32'd3);
    rst = 1'b1;
    tick();
    chk("t5_rst_bus", 32'({o_SSER, o_BR_W, o_key_clk, o_BA13, o_BA12}), 32'b1_0_0_1_0);
    chk("t5_rst_dv", 32'({o_data_valid, o_busy, o_cmd_ready}), 32'b0_0_1);
    rst = 1'b0;
    tick();
    load_key(8, 0);
    start_cmd(4'h5, 8'd8);
    wait_idle("t5", 200, cyc);
    chk("t5_pulses", 32'(pulses), 32'd8);
    expect_bytes(8);
    check_bytes("t5");

    // 6: 48 random key bits, random backpressure
    bus_err = 0;
    ready_mode = 2;
    load_key(48, 0);
    start_cmd(4'hA, 8'd48);
    wait_idle("t6", 3000, cyc);
    chk("t6_bus", 32'(bus_err), 32'd0);
    chk("t6_pulses", 32'(pulses), 32'd48);
    expect_bytes(48);
    check_bytes("t6");

    // random commands
    for (int k = 0; k < 4; k++) begin
      len = $urandom_range(1, 40);
      ready_mode = $urandom_range(1, 2);
      load_key(len, 0);
      start_cmd(4'($urandom_range(0, 15)), 8'(len));
      wait_idle($sformatf("rnd%0d", k), 3000, cyc);
      expect_bytes(len);
      check_bytes($sformatf("rnd%0d", k));
    end

    // maximum length
    ready_mode = 1;
    tick();
    load_key(255, 0);
    start_cmd(4'hC, 8'd255);
    wait_idle("t255", 4000, cyc);
    chk("t255_cycles", 32'(cyc), 32'(255 * LAT_BIT + 32));
    expect_bytes(255);
    check_bytes("t255");
    if (got_d.size() == 32) chk("t255_bit7", 32'(got_d[31][7]), 32'd0);
    chk("bus_total", 32'(bus_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
